// File: rtl/fwd_hazard_ctrl.sv
// Execute-stage operand forwarding and load-use stall controller.
// Optional statistics counters built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_ctrl #(
  parameter int REG_AW     = 3,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_de,
  input  logic [REG_AW-1:0] rt_de,
  input  logic              rsv_de,
  input  logic              rtv_de,
  input  logic              de_valid,
  input  logic [REG_AW-1:0] rd_em,
  input  logic              rdv_em,
  input  logic              regwrite_em,
  input  logic              readmem_em,
  input  logic [REG_AW-1:0] rd_mw,
  input  logic              rdv_mw,
  input  logic              regwrite_mw,
  input  logic              mem_stall,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_ex,
  output logic              bubble_em,
  output logic              wb_capture,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
);

  localparam int CW = $clog2(LOAD_STALL + 1);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            hold_a, hold_a_nx;
  logic            hold_b, hold_b_nx;
  logic            lat_a, lat_a_nx;
  logic            lat_b, lat_b_nx;
  logic            ld_in_mw, ld_in_mw_nx;

  logic em_hit_a, em_hit_b;
  logic mw_hit_a, mw_hit_b;
  logic luh;
  logic cnt_nz;

  assign em_hit_a = regwrite_em & rdv_em & rsv_de
                  & de_valid & (rs_de == rd_em);
  assign em_hit_b = regwrite_em & rdv_em & rtv_de
                  & de_valid & (rt_de == rd_em);
  assign mw_hit_a = regwrite_mw & rdv_mw & rsv_de
                  & de_valid & (rs_de == rd_mw);
  assign mw_hit_b = regwrite_mw & rdv_mw & rtv_de
                  & de_valid & (rt_de == rd_mw);

  assign luh    = (em_hit_a | em_hit_b) & readmem_em;
  assign cnt_nz = (cnt != '0);

  // A load still in EM cannot supply data yet, so it yields 00.
  always_comb begin
    forward_a = 2'b00;
    if (hold_a)
      forward_a = 2'b11;
    else if (state == STALL && ld_in_mw && lat_a)
      forward_a = 2'b01;
    else if (em_hit_a)
      forward_a = readmem_em ? 2'b00 : 2'b10;
    else if (mw_hit_a)
      forward_a = 2'b01;
  end

  always_comb begin
    forward_b = 2'b00;
    if (hold_b)
      forward_b = 2'b11;
    else if (state == STALL && ld_in_mw && lat_b)
      forward_b = 2'b01;
    else if (em_hit_b)
      forward_b = readmem_em ? 2'b00 : 2'b10;
    else if (mw_hit_b)
      forward_b = 2'b01;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    hold_a_nx   = hold_a;
    hold_b_nx   = hold_b;
    lat_a_nx    = lat_a;
    lat_b_nx    = lat_b;
    ld_in_mw_nx = ld_in_mw;
    stall_ex    = 1'b0;
    bubble_em   = 1'b0;
    wb_capture  = 1'b0;
    unique case (state)
      IDLE: begin
        stall_ex  = luh;
        bubble_em = luh;
        if (luh) begin
          state_nx    = STALL;
          cnt_nx      = CW'(LOAD_STALL - 1);
          lat_a_nx    = em_hit_a;
          lat_b_nx    = em_hit_b;
          ld_in_mw_nx = 1'b1;
        end
      end
      STALL: begin
        stall_ex   = cnt_nz;
        bubble_em  = cnt_nz;
        wb_capture = ld_in_mw;
        if (ld_in_mw) begin
          hold_a_nx   = lat_a;
          hold_b_nx   = lat_b;
          ld_in_mw_nx = 1'b0;
        end
        if (cnt_nz) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          state_nx    = IDLE;
          hold_a_nx   = 1'b0;
          hold_b_nx   = 1'b0;
          lat_a_nx    = 1'b0;
          lat_b_nx    = 1'b0;
          ld_in_mw_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_a   <= 1'b0;
      hold_b   <= 1'b0;
      lat_a    <= 1'b0;
      lat_b    <= 1'b0;
      ld_in_mw <= 1'b0;
    end else if (!mem_stall) begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      hold_a   <= hold_a_nx;
      hold_b   <= hold_b_nx;
      lat_a    <= lat_a_nx;
      lat_b    <= lat_b_nx;
      ld_in_mw <= ld_in_mw_nx;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_q, fwd_q;
  logic        fwd_any;

  assign fwd_any = (forward_a != 2'b00) | (forward_b != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      fwd_q   <= '0;
    end else if (!mem_stall) begin
      if (stall_ex && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (fwd_any && fwd_q != 16'hFFFF)
        fwd_q <= fwd_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign fwd_cnt   = fwd_q;
`else
  assign stall_cnt = 16'h0000;
  assign fwd_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl.
// Three instances cover LOAD_STALL = 1, 2 and 3.
module tb_fwd_hazard_ctrl;

  localparam int AW = 3;
`ifdef FWD_HAZARD_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_de, rt_de, rd_em, rd_mw;
  logic          rsv_de, rtv_de, de_valid;
  logic          rdv_em, regwrite_em, readmem_em;
  logic          rdv_mw, regwrite_mw, mem_stall;

  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        stl [3];
  logic        bub [3];
  logic        wbc [3];
  logic [15:0] scnt [3];
  logic [15:0] fcnt [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(1)) u1 (
    .clk(clk), .rst(rst),
    .rs_de(rs_de), .rt_de(rt_de),
    .rsv_de(rsv_de), .rtv_de(rtv_de), .de_valid(de_valid),
    .rd_em(rd_em), .rdv_em(rdv_em),
    .regwrite_em(regwrite_em), .readmem_em(readmem_em),
    .rd_mw(rd_mw), .rdv_mw(rdv_mw), .regwrite_mw(regwrite_mw),
    .mem_stall(mem_stall),
    .forward_a(fa[0]), .forward_b(fb[0]),
    .stall_ex(stl[0]), .bubble_em(bub[0]), .wb_capture(wbc[0]),
    .stall_cnt(scnt[0]), .fwd_cnt(fcnt[0])
  );

  fwd_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(2)) u2 (
    .clk(clk), .rst(rst),
    .rs_de(rs_de), .rt_de(rt_de),
    .rsv_de(rsv_de), .rtv_de(rtv_de), .de_valid(de_valid),
    .rd_em(rd_em), .rdv_em(rdv_em),
    .regwrite_em(regwrite_em), .readmem_em(readmem_em),
    .rd_mw(rd_mw), .rdv_mw(rdv_mw), .regwrite_mw(regwrite_mw),
    .mem_stall(mem_stall),
    .forward_a(fa[1]), .forward_b(fb[1]),
    .stall_ex(stl[1]), .bubble_em(bub[1]), .wb_capture(wbc[1]),
    .stall_cnt(scnt[1]), .fwd_cnt(fcnt[1])
  );

  fwd_hazard_ctrl #(.REG_AW(AW), .LOAD_STALL(3)) u3 (
    .clk(clk), .rst(rst),
    .rs_de(rs_de), .rt_de(rt_de),
    .rsv_de(rsv_de), .rtv_de(rtv_de), .de_valid(de_valid),
    .rd_em(rd_em), .rdv_em(rdv_em),
    .regwrite_em(regwrite_em), .readmem_em(readmem_em),
    .rd_mw(rd_mw), .rdv_mw(rdv_mw), .regwrite_mw(regwrite_mw),
    .mem_stall(mem_stall),
    .forward_a(fa[2]), .forward_b(fb[2]),
    .stall_ex(stl[2]), .bubble_em(bub[2]), .wb_capture(wbc[2]),
    .stall_cnt(scnt[2]), .fwd_cnt(fcnt[2])
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic set_de(input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt,
                        input logic sv, input logic tv,
                        input logic v);
    rs_de = rs; rt_de = rt;
    rsv_de = sv; rtv_de = tv; de_valid = v;
  endtask

  task automatic set_em(input logic [AW-1:0] rd,
                        input logic dv, input logic rw,
                        input logic rm);
    rd_em = rd; rdv_em = dv;
    regwrite_em = rw; readmem_em = rm;
  endtask

  task automatic set_mw(input logic [AW-1:0] rd,
                        input logic dv, input logic rw);
    rd_mw = rd; rdv_mw = dv; regwrite_mw = rw;
  endtask

  task automatic clr();
    set_de('0, '0, 1'b0, 1'b0, 1'b0);
    set_em('0, 1'b0, 1'b0, 1'b0);
    set_mw('0, 1'b0, 1'b0);
    mem_stall = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    clr();
    nx();
    nx();
    rst = 1'b0;
  endtask

  initial begin
    do_rst();

    // reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_fa", 16'(fa[i]), 16'd0);
      chk("rst_stall", 16'(stl[i]), 16'd0);
      chk("rst_scnt", scnt[i], 16'd0);
      chk("rst_fcnt", fcnt[i], 16'd0);
    end
    nx();

    // ALU result in EM feeding both operands
    set_em(3'd1, 1'b1, 1'b1, 1'b0);
    set_de(3'd1, 3'd1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("add_fa", 16'(fa[0]), 16'd2);
    chk("add_fb", 16'(fb[0]), 16'd2);
    chk("add_stall", 16'(stl[0]), 16'd0);
    rsv_de = 1'b0;
    #1;
    chk("rsv0_fa", 16'(fa[0]), 16'd0);
    chk("rsv0_fb", 16'(fb[0]), 16'd2);
    de_valid = 1'b0;
    #1;
    chk("nv_fb", 16'(fb[0]), 16'd0);
    nx();

    // EM wins over MW, MW used when EM invalid
    set_em(3'd2, 1'b1, 1'b1, 1'b0);
    set_mw(3'd2, 1'b1, 1'b1);
    set_de(3'd2, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("prio_fa", 16'(fa[0]), 16'd2);
    rdv_em = 1'b0;
    #1;
    chk("mw_fa", 16'(fa[0]), 16'd1);
    nx();

    // LOAD_STALL=1, rs uses load r3
    do_rst();
    set_em(3'd3, 1'b1, 1'b1, 1'b1);
    set_de(3'd3, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("l1c0_stall", 16'(stl[0]), 16'd1);
    chk("l1c0_bub", 16'(bub[0]), 16'd1);
    chk("l1c0_fa", 16'(fa[0]), 16'd0);
    nx();
    set_em('0, 1'b0, 1'b0, 1'b0);
    set_mw(3'd3, 1'b1, 1'b1);
    @(negedge clk);
    chk("l1c1_stall", 16'(stl[0]), 16'd0);
    chk("l1c1_wbc", 16'(wbc[0]), 16'd1);
    chk("l1c1_fa", 16'(fa[0]), 16'd1);
    nx();
    set_mw('0, 1'b0, 1'b0);
    set_de(3'd5, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("l1c2_stall", 16'(stl[0]), 16'd0);
    chk("l1c2_wbc", 16'(wbc[0]), 16'd0);
    chk("l1c2_fa", 16'(fa[0]), 16'd0);
    nx();

    // LOAD_STALL=3, rt uses load r4
    do_rst();
    set_em(3'd4, 1'b1, 1'b1, 1'b1);
    set_de(3'd0, 3'd4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("l3c0_stall", 16'(stl[2]), 16'd1);
    chk("l3c0_bub", 16'(bub[2]), 16'd1);
    chk("l3c0_fb", 16'(fb[2]), 16'd0);
    nx();
    set_em('0, 1'b0, 1'b0, 1'b0);
    set_mw(3'd4, 1'b1, 1'b1);
    @(negedge clk);
    chk("l3c1_stall", 16'(stl[2]), 16'd1);
    chk("l3c1_wbc", 16'(wbc[2]), 16'd1);
    chk("l3c1_fb", 16'(fb[2]), 16'd1);
    nx();
    set_mw('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("l3c2_stall", 16'(stl[2]), 16'd1);
    chk("l3c2_wbc", 16'(wbc[2]), 16'd0);
    chk("l3c2_fb", 16'(fb[2]), 16'd3);
    nx();
    @(negedge clk);
    chk("l3c3_stall", 16'(stl[2]), 16'd0);
    chk("l3c3_bub", 16'(bub[2]), 16'd0);
    chk("l3c3_fb", 16'(fb[2]), 16'd3);
    nx();
    set_de(3'd0, 3'd6, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("l3c4_stall", 16'(stl[2]), 16'd0);
    chk("l3c4_fb", 16'(fb[2]), 16'd0);
    chk("l3_scnt", scnt[2], ST ? 16'd3 : 16'd0);
    chk("l3_fcnt", fcnt[2], ST ? 16'd3 : 16'd0);
    nx();

    // LOAD_STALL=2 with two frozen cycles
    do_rst();
    set_em(3'd6, 1'b1, 1'b1, 1'b1);
    set_de(3'd6, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("ms_c0_stall", 16'(stl[1]), 16'd1);
    nx();
    set_em('0, 1'b0, 1'b0, 1'b0);
    set_mw(3'd6, 1'b1, 1'b1);
    mem_stall = 1'b1;
    @(negedge clk);
    chk("ms_c1_wbc", 16'(wbc[1]), 16'd1);
    chk("ms_c1_stall", 16'(stl[1]), 16'd1);
    nx();
    @(negedge clk);
    chk("ms_c2_wbc", 16'(wbc[1]), 16'd1);
    chk("ms_c2_stall", 16'(stl[1]), 16'd1);
    nx();
    mem_stall = 1'b0;
    @(negedge clk);
    chk("ms_c3_wbc", 16'(wbc[1]), 16'd1);
    chk("ms_c3_stall", 16'(stl[1]), 16'd1);
    chk("ms_c3_fa", 16'(fa[1]), 16'd1);
    nx();
    set_mw('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ms_c4_stall", 16'(stl[1]), 16'd0);
    chk("ms_c4_wbc", 16'(wbc[1]), 16'd0);
    chk("ms_c4_fa", 16'(fa[1]), 16'd3);
    nx();
    set_de(3'd1, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("ms_c5_stall", 16'(stl[1]), 16'd0);
    chk("ms_c5_fa", 16'(fa[1]), 16'd0);
    chk("ms_scnt", scnt[1], ST ? 16'd2 : 16'd0);
    chk("ms_fcnt", fcnt[1], ST ? 16'd2 : 16'd0);
    nx();

    // reset while in STALL
    do_rst();
    set_em(3'd4, 1'b1, 1'b1, 1'b1);
    set_de(3'd0, 3'd4, 1'b0, 1'b1, 1'b1);
    nx();
    set_em('0, 1'b0, 1'b0, 1'b0);
    set_mw(3'd4, 1'b1, 1'b1);
    @(negedge clk);
    chk("rs_c1_stall", 16'(stl[2]), 16'd1);
    rst = 1'b1;
    nx();
    rst = 1'b0;
    clr();
    @(negedge clk);
    chk("rs_stall", 16'(stl[2]), 16'd0);
    chk("rs_bub", 16'(bub[2]), 16'd0);
    chk("rs_wbc", 16'(wbc[2]), 16'd0);
    chk("rs_fb", 16'(fb[2]), 16'd0);
    chk("rs_scnt", scnt[2], 16'd0);
    chk("rs_fcnt", fcnt[2], 16'd0);
    set_de(3'd0, 3'd4, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rs_nohold", 16'(fb[2]), 16'd0);
    nx();
    @(negedge clk);
    chk("rs_idle", 16'(stl[2]), 16'd0);
    nx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and load-use hazard controller for the execute stage. Combines EM/MW operand-forwarding selection with a stall state machine that holds the consumer in EX for a configurable number of load-latency cycles, and captures retiring load data so the value is not lost under long stalls. Sits beside the DE/EX, EX/MEM and MEM/WB pipeline latches; drives the EX operand muxes, the DE/EX hold, the EX/MEM bubble insert and a capture latch in the datapath.

## Interface
- REG_AW, 3, register-address width
- LOAD_STALL, 1, stall cycles inserted on a load-use hazard (1..15)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs_de, rt_de  in  REG_AW  source registers of instruction in EX (DE/EX latch)
- rsv_de, rtv_de  in  1  source is actually read
- de_valid  in  1  DE/EX latch holds a real instruction
- rd_em  in  REG_AW  destination in EX/MEM latch; rdv_em, regwrite_em, readmem_em  in  1 each
- rd_mw  in  REG_AW  destination in MEM/WB latch; rdv_mw, regwrite_mw  in  1 each
- mem_stall  in  1  external memory busy; whole pipeline frozen this cycle
- forward_a, forward_b  out  2  00 regfile, 01 MW, 10 EM, 11 capture latch
- stall_ex  out  1  hold PC, IF/DE and DE/EX latches
- bubble_em  out  1  load NOP into EX/MEM
- wb_capture  out  1  datapath captures MW write data into capture latch
- stall_cnt, fwd_cnt  out  16 each  statistics (see Configuration)

## Operation
- Match terms: em_hit_x = regwrite_em & rdv_em & srcv_x & de_valid & (src_x==rd_em); mw_hit_x likewise with MW fields. Priority per operand: hold_x → 11, else em_hit_x → 10, else mw_hit_x → 01, else 00.
- Load-use hazard luh = em_hit_a|em_hit_b with readmem_em=1. Load in EM never forwarded as 10; that operand gets 00 while stalled.
- States: IDLE, STALL. cnt is ceil(log2(LOAD_STALL+1)) bits.
- IDLE: luh → stall_ex=1, bubble_em=1 same cycle; on edge (if !mem_stall) → STALL, cnt=LOAD_STALL-1, latch hit_a/hit_b, set ld_in_mw. If LOAD_STALL==1 and cnt==0, STALL is a single release cycle.
- STALL: stall_ex=bubble_em=(cnt!=0). ld_in_mw=1 → wb_capture=1; on edge (if !mem_stall) set hold_x for latched operands, clear ld_in_mw. In the ld_in_mw cycle latched operands select 01; afterwards 11. cnt decrements each non-frozen edge; at cnt==0 the consumer advances, next edge → IDLE, hold_a/hold_b cleared.
- mem_stall=1: no state, cnt, hold or flag update; outputs recomputed from frozen inputs.
- New luh while in STALL is ignored (cannot occur: EM holds a bubble).

## Timing
- Forward, stall_ex, bubble_em, wb_capture: combinational from inputs and current state, valid in the cycle of the match.
- Load-use penalty exactly LOAD_STALL cycles plus mem_stall cycles.
- Reset: state IDLE, cnt=0, hold_a/hold_b/ld_in_mw=0; all outputs 0 (forward 00, counters 0) from the first cycle after rst sampled high. rst mid-stall aborts immediately; pipeline flushed by the owner.
- rst takes priority over mem_stall.

## Configuration
- FWD_HAZARD_STATS_EN defined: stall_cnt increments each cycle stall_ex=1 and !mem_stall; fwd_cnt increments each non-frozen cycle with forward_a!=00 or forward_b!=00 (+1 per cycle, not per operand); both saturate at 16'hFFFF, clear on rst.
- Undefined: counters not built; stall_cnt and fwd_cnt tied to 0.

## Test plan
- ADD r1 in EM, consumer rs=r1, rt=r1 in EX, no load → forward_a=forward_b=10, stall_ex=0.
- r2 written in both EM and MW, rs=r2 → forward_a=10 (EM priority); EM rdv_em=0 → 01.
- LOAD_STALL=1, LW r3 in EM, rs=r3 → cycle 0 stall_ex=bubble_em=1, forward_a=00; cycle 1 stall_ex=0, wb_capture=1, forward_a=01; cycle 2 IDLE.
- LOAD_STALL=3, LW r4 in EM, rt=r4 → stall_ex=1 cycles 0–2, wb_capture in cycle 1, forward_b=01 cycle 1, 11 cycles 2–3, release in cycle 3; stall_cnt=3.
- LOAD_STALL=2, mem_stall=1 for 2 cycles starting cycle 1 → wb_capture held high cycles 1–3, release delayed 2 cycles.
- rst asserted in STALL cycle 1 → next cycle all outputs 0, state IDLE, counters 0.
